// File: rtl/rotor_pkg.sv
// rotor_pkg: shared direction encoding, defaults and width helper for rotor consumers
package rotor_pkg;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_LEFT = 2'd1, DIR_RIGHT = 2'd2} dir_t;
  localparam int FAST_WINDOW_DEF = 500000;
  localparam int FAST_STEP_DEF = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rotor_rate_timer.sv
// rotor_rate_timer: saturating gap counter since the last event, flags fast events
module rotor_rate_timer import rotor_pkg::*; #(
  parameter int FAST_WINDOW = FAST_WINDOW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic expire,
  output logic fast
);
  localparam int TW = clog2(FAST_WINDOW + 1);
  localparam logic [TW-1:0] SAT = TW'(FAST_WINDOW);
  logic [TW-1:0] gap;
  always_ff @(posedge clk or negedge rst)
    if (!rst) gap <= SAT;
    else gap <= expire ? SAT : restart ? '0 : (gap == SAT) ? gap : gap + 1'b1;
  assign fast = gap < SAT;
endmodule

// File: rtl/rotor_accum.sv
// rotor_accum: bounded position accumulator for left/right detent pulses with acceleration
module rotor_accum import rotor_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int MIN = 0,
  parameter int MAX = 255,
  parameter int INIT = 0,
  parameter int WRAP = 0,
  parameter int FAST_WINDOW = FAST_WINDOW_DEF,
  parameter int FAST_STEP = FAST_STEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             at_min,
  output logic             at_max
);
  typedef logic [WIDTH:0] ext_t;
  localparam ext_t LO = ext_t'(MIN);
  localparam ext_t HI = ext_t'(MAX);
  localparam ext_t SPAN = ext_t'(MAX - MIN + 1);
  localparam ext_t FSTEP = ext_t'(FAST_STEP);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  logic ev, fast;
  dir_t dir, ev_dir;
  ext_t cur, step, up, res;
  logic [WIDTH-1:0] nxt;
  rotor_rate_timer #(.FAST_WINDOW(FAST_WINDOW)) u_timer (
    .clk(clk),
    .rst(rst),
    .restart(ev && !clear),
    .expire(clear),
    .fast(fast)
  );
  // both directions at once is treated as noise and leaves all state alone
  always_comb begin
    ev = left ^ right;
    ev_dir = right ? DIR_RIGHT : DIR_LEFT;
    cur = {1'b0, value};
    step = (fast && ev_dir == dir) ? FSTEP : ext_t'(1);
    up = cur + step;
    res = right ? ((up > HI) ? ((WRAP != 0) ? up - SPAN : HI) : up)
                : ((cur < LO + step) ? ((WRAP != 0) ? cur + SPAN - step : LO) : cur - step);
    nxt = clear ? INIT_V : ev ? WIDTH'(res) : value;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      value <= INIT_V;
      changed <= 1'b0;
      dir <= DIR_NONE;
    end else begin
      value <= nxt;
      changed <= nxt != value;
      dir <= clear ? DIR_NONE : ev ? ev_dir : dir;
    end
  assign at_min = value == WIDTH'(MIN);
  assign at_max = value == WIDTH'(MAX);
endmodule

// File: tb/tb_rotor_accum.sv
// tb_rotor_accum: directed checks of saturate and wrap accumulators with acceleration
module tb_rotor_accum;
  logic clk = 0, rst = 0, left = 0, right = 0, clear = 0;
  logic [7:0] v0, v1;
  logic c0, c1, mn0, mn1, mx0, mx1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rotor_accum #(.WIDTH(8), .MIN(10), .MAX(20), .INIT(15), .WRAP(0), .FAST_WINDOW(16), .FAST_STEP(4)) u_sat (
    .clk(clk), .rst(rst), .left(left), .right(right), .clear(clear),
    .value(v0), .changed(c0), .at_min(mn0), .at_max(mx0));
  rotor_accum #(.WIDTH(8), .MIN(10), .MAX(20), .INIT(15), .WRAP(1), .FAST_WINDOW(16), .FAST_STEP(4)) u_wrap (
    .clk(clk), .rst(rst), .left(left), .right(right), .clear(clear),
    .value(v1), .changed(c1), .at_min(mn1), .at_max(mx1));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pulse(input string tag, input logic l, input logic r, input int sp, input bit w,
                       input int ev, input int ec);
    left = l;
    right = r;
    @(negedge clk);
    left = 0;
    right = 0;
    check({tag, "_v"}, w ? int'(v1) : int'(v0), ev);
    check({tag, "_c"}, w ? int'(c1) : int'(c0), ec);
    if (sp > 1) begin
      @(negedge clk);
      check({tag, "_c_next"}, w ? int'(c1) : int'(c0), 0);
      repeat (sp - 2) @(negedge clk);
    end
  endtask
  task automatic do_clear(input string tag, input logic r, input int ec);
    clear = 1;
    right = r;
    @(negedge clk);
    clear = 0;
    right = 0;
    check({tag, "_v"}, int'(v0), 15);
    check({tag, "_c"}, int'(c0), ec);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_v", int'(v0), 15);
    check("rst_c", int'(c0), 0);
    check("rst_min", int'(mn0), 0);
    check("rst_max", int'(mx0), 0);
    rst = 1;
    @(negedge clk);
    pulse("t1a", 0, 1, 40, 0, 16, 1);
    pulse("t1b", 0, 1, 40, 0, 17, 1);
    pulse("t1c", 0, 1, 40, 0, 18, 1);
    check("t1_max", int'(mx0), 0);
    do_clear("t2_clr", 0, 1);
    pulse("t2r1", 0, 1, 40, 0, 16, 1);
    pulse("t2r2", 0, 1, 40, 0, 17, 1);
    pulse("t2r3", 0, 1, 40, 0, 18, 1);
    pulse("t2r4", 0, 1, 40, 0, 19, 1);
    pulse("t2r5", 0, 1, 40, 0, 20, 1);
    pulse("t2r6", 0, 1, 40, 0, 20, 0);
    pulse("t2r7", 0, 1, 40, 0, 20, 0);
    pulse("t2r8", 0, 1, 40, 0, 20, 0);
    check("t2_max", int'(mx0), 1);
    pulse("t2l", 1, 0, 40, 0, 19, 1);
    do_clear("t3_clr", 0, 1);
    pulse("t3r1", 0, 1, 40, 1, 16, 1);
    pulse("t3r2", 0, 1, 40, 1, 17, 1);
    pulse("t3r3", 0, 1, 40, 1, 18, 1);
    pulse("t3r4", 0, 1, 40, 1, 19, 1);
    pulse("t3r5", 0, 1, 40, 1, 20, 1);
    pulse("t3r6", 0, 1, 40, 1, 10, 1);
    check("t3_min", int'(mn1), 1);
    pulse("t3l", 1, 0, 40, 1, 20, 1);
    check("t3_max", int'(mx1), 1);
    do_clear("t4_clr", 0, 1);
    pulse("t4l1", 1, 0, 5, 0, 14, 1);
    pulse("t4l2", 1, 0, 5, 0, 10, 1);
    pulse("t4l3", 1, 0, 5, 0, 10, 0);
    check("t4_min", int'(mn0), 1);
    pulse("t4rev", 0, 1, 40, 0, 11, 1);
    do_clear("t5_clr", 0, 1);
    pulse("t5l1", 1, 0, 5, 0, 14, 1);
    pulse("t5both", 1, 1, 5, 0, 14, 0);
    pulse("t5l2", 1, 0, 40, 0, 10, 1);
    do_clear("t5b_clr", 0, 1);
    pulse("t5br1", 0, 1, 10, 0, 16, 1);
    pulse("t5bboth", 1, 1, 10, 0, 16, 0);
    pulse("t5br2", 0, 1, 40, 0, 17, 1);
    do_clear("win_clr", 0, 1);
    pulse("win16a", 0, 1, 16, 0, 16, 1);
    pulse("win16b", 0, 1, 40, 0, 20, 1);
    do_clear("win17_clr", 0, 1);
    pulse("win17a", 0, 1, 17, 0, 16, 1);
    pulse("win17b", 0, 1, 40, 0, 17, 1);
    pulse("e_r1", 0, 1, 40, 0, 18, 1);
    do_clear("e_clr_ev", 1, 1);
    pulse("e_after_clr", 0, 1, 5, 0, 16, 1);
    pulse("e_fast", 0, 1, 40, 0, 20, 1);
    do_clear("e_clr1", 0, 1);
    do_clear("e_clr_init", 0, 0);
    pulse("e_pre", 0, 1, 5, 0, 16, 1);
    right = 1;
    @(posedge clk);
    #2;
    right = 0;
    check("e_pre_rst_v", int'(v0), 20);
    check("e_pre_rst_c", int'(c0), 1);
    rst = 0;
    #1;
    check("e_arst_v", int'(v0), 15);
    check("e_arst_c", int'(c0), 0);
    check("e_arst_max", int'(mx0), 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    pulse("e_first", 0, 1, 40, 0, 16, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
